// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds the FSM state codes, opcode/funct constants, ALU control codes and
// the datapath mux encodings used by the controller and its ALU decoder.
package mips_ctrl_pkg;

    // FSM state encoding (4 bits, kept as plain constants for legacy tools)
    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTE  = 4'd6;
    localparam state_t S_ALUWB    = 4'd7;
    localparam state_t S_BRANCH   = 4'd8;
    localparam state_t S_ADDIEXEC = 4'd9;
    localparam state_t S_ADDIWB   = 4'd10;
    localparam state_t S_JUMP     = 4'd11;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle.
//   Inputs to controller : op, funct (from IR), zero (ALU), mem_ready (memory)
//   Outputs of controller: datapath selects/enables, illegal_op, mem_timeout,
//                          plus state and wait_cnt for observation.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if #(
    parameter int CNT_W = 5
);
    import mips_ctrl_pkg::*;

    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;

    logic             pc_en;
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic [2:0]       alu_control;
    logic             illegal_op;
    logic             mem_timeout;
    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_en, iord, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control,
               illegal_op, mem_timeout, state, wait_cnt
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_en, iord, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control,
               illegal_op, mem_timeout, state, wait_cnt
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational R-type ALU decoder.
//   funct       in  6  instr[5:0]
//   alu_control out 3  ALU function code (add for unknown functs)
//   funct_legal out 1  funct is one of add/sub/and/or/slt
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_legal
);

    always_comb begin
        alu_control = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FUNCT_ADD: alu_control = ALU_ADD;
            FUNCT_SUB: alu_control = ALU_SUB;
            FUNCT_AND: alu_control = ALU_AND;
            FUNCT_OR:  alu_control = ALU_OR;
            FUNCT_SLT: alu_control = ALU_SLT;
            default:   funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath.
// Sequences one instruction over 3-5 cycles on a shared memory port and
// waits on mem_ready in FETCH, MEMREAD and MEMWRITE with an optional timeout.
//   clk    in  1  rising-edge clock
//   reset  in  1  synchronous active-high reset
//   bus    master modport of multicycle_controller_if (IR fields, zero,
//          mem_ready in; all datapath selects/enables and status out)
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.master  bus
);

    state_t           state;
    state_t           next_state;
    state_t           out_state;
    logic [CNT_W-1:0] cnt;
    logic             illegal_q;
    logic             timeout_q;
    logic [2:0]       alu_ctl_fn;
    logic             funct_legal;
    logic             in_wait;
    logic             timeout_hit;
    logic             decode_illegal;

    logic c_pc_en, c_iord, c_mem_write, c_ir_write, c_reg_write;
    logic c_reg_dst, c_mem_to_reg, c_alu_src_a;
    logic [1:0] c_alu_src_b, c_pc_src;
    logic [2:0] c_alu_control;

    alu_decoder u_alu_dec (
        .funct       (bus.funct),
        .alu_control (alu_ctl_fn),
        .funct_legal (funct_legal)
    );

    assign in_wait = (state == S_FETCH) || (state == S_MEMREAD) ||
                     (state == S_MEMWRITE);
    assign timeout_hit = (TIMEOUT != 0) && in_wait && !bus.mem_ready &&
                         (int'(cnt) == TIMEOUT);

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = funct_legal ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) next_state = S_FETCH;
            S_EXECUTE:  next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_ADDIEXEC: next_state = S_ADDIWB;
            S_ADDIWB:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
        if (timeout_hit) next_state = S_FETCH;
    end

    // DECODE only falls back to FETCH when the op/funct is unsupported
    assign decode_illegal = (state == S_DECODE) && (next_state == S_FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            cnt       <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= next_state;
            illegal_q <= decode_illegal;
            // A timeout in FETCH keeps the state, so it must clear the count too
            if ((next_state != state) || timeout_hit)
                cnt <= '0;
            else if (in_wait && !bus.mem_ready && (cnt != '1))
                cnt <= cnt + 1'b1;
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end

    // While reset is high the outputs decode as FETCH regardless of state
    assign out_state = reset ? S_FETCH : state;

    always_comb begin
        c_pc_en       = 1'b0;
        c_iord        = 1'b0;
        c_mem_write   = 1'b0;
        c_ir_write    = 1'b0;
        c_reg_write   = 1'b0;
        c_reg_dst     = 1'b0;
        c_mem_to_reg  = 1'b0;
        c_alu_src_a   = 1'b0;
        c_alu_src_b   = SRCB_RT;
        c_pc_src      = PCSRC_ALU;
        c_alu_control = ALU_ADD;
        case (out_state)
            S_FETCH: begin
                c_alu_src_b = SRCB_FOUR;
                c_ir_write  = bus.mem_ready;
                c_pc_en     = bus.mem_ready;
            end
            S_DECODE:   c_alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  c_iord = 1'b1;
            S_MEMWB: begin
                c_reg_write  = 1'b1;
                c_mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                c_iord      = 1'b1;
                c_mem_write = !timeout_hit;
            end
            S_EXECUTE: begin
                c_alu_src_a   = 1'b1;
                c_alu_control = alu_ctl_fn;
            end
            S_ALUWB: begin
                c_reg_write = 1'b1;
                c_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c_alu_src_a   = 1'b1;
                c_alu_control = ALU_SUB;
                c_pc_src      = PCSRC_ALUOUT;
                c_pc_en       = bus.zero;
            end
            S_ADDIEXEC: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = SRCB_IMM;
            end
            S_ADDIWB:   c_reg_write = 1'b1;
            S_JUMP: begin
                c_pc_src = PCSRC_JUMP;
                c_pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pc_en       = c_pc_en & !reset;
    assign bus.mem_write   = c_mem_write & !reset;
    assign bus.ir_write    = c_ir_write & !reset;
    assign bus.reg_write   = c_reg_write & !reset;
    assign bus.iord        = c_iord;
    assign bus.reg_dst     = c_reg_dst;
    assign bus.mem_to_reg  = c_mem_to_reg;
    assign bus.alu_src_a   = c_alu_src_a;
    assign bus.alu_src_b   = c_alu_src_b;
    assign bus.pc_src      = c_pc_src;
    assign bus.alu_control = c_alu_control;
    assign bus.illegal_op  = illegal_q;
    assign bus.mem_timeout = timeout_q;
    assign bus.state       = state;
    assign bus.wait_cnt    = cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process pushes the
// hand-derived expected outputs for every cycle, a monitor pops and compares.
module tb_multicycle_controller;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       illegal_op;
        logic       mem_timeout;
        logic [3:0] state;
        logic [4:0] cnt;
    } obs_t;

    logic clk;
    logic reset;

    multicycle_controller_if #(.CNT_W(5)) bus ();

    multicycle_controller #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string name_q[$];
    int    total  = 0;
    int    passed = 0;

    logic [5:0] op_v, fn_v;
    logic       z_v, rdy_v, rst_v, to_exp;

    // Spec table of Moore outputs per state; gated terms left 0 for callers
    function automatic obs_t ex(input state_t st, input int c);
        obs_t e;
        e = '0;
        e.alu_control = 3'b010;
        e.state = st;
        e.cnt = 5'(c);
        e.mem_timeout = to_exp;
        case (st)
            S_FETCH:    e.alu_src_b = 2'b01;
            S_DECODE:   e.alu_src_b = 2'b11;
            S_MEMADR:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            S_MEMREAD:  e.iord = 1'b1;
            S_MEMWB:    begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            S_MEMWRITE: begin e.iord = 1'b1; e.mem_write = 1'b1; end
            S_EXECUTE:  e.alu_src_a = 1'b1;
            S_ALUWB:    begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
            S_BRANCH:   begin e.alu_src_a = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01; end
            S_ADDIEXEC: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            S_ADDIWB:   e.reg_write = 1'b1;
            S_JUMP:     begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic cyc(input string nm, input obs_t e);
        bus.op        = op_v;
        bus.funct     = fn_v;
        bus.zero      = z_v;
        bus.mem_ready = rdy_v;
        reset         = rst_v;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch1(input string nm);
        obs_t e;
        rdy_v = 1'b1;
        e = ex(S_FETCH, 0);
        e.ir_write = 1'b1;
        e.pc_en = 1'b1;
        cyc(nm, e);
    endtask

    // Monitor: compares every cycle for which an expectation was queued
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a.pc_en       = bus.pc_en;
            a.iord        = bus.iord;
            a.mem_write   = bus.mem_write;
            a.ir_write    = bus.ir_write;
            a.reg_write   = bus.reg_write;
            a.reg_dst     = bus.reg_dst;
            a.mem_to_reg  = bus.mem_to_reg;
            a.alu_src_a   = bus.alu_src_a;
            a.alu_src_b   = bus.alu_src_b;
            a.pc_src      = bus.pc_src;
            a.alu_control = bus.alu_control;
            a.illegal_op  = bus.illegal_op;
            a.mem_timeout = bus.mem_timeout;
            a.state       = bus.state;
            a.cnt         = bus.wait_cnt;
            total++;
            if (a !== e)
                $display("FAIL %s: got %b want %b (fields pc_en..cnt)", nm, a, e);
            else
                passed++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        obs_t e;
        op_v = 6'h00; fn_v = 6'h20; z_v = 1'b0; rdy_v = 1'b1; rst_v = 1'b1; to_exp = 1'b0;
        bus.op = op_v; bus.funct = fn_v; bus.zero = z_v; bus.mem_ready = rdy_v; reset = rst_v;
        @(posedge clk);
        #1;

        // reset: FETCH values, write enables forced low even with mem_ready=1
        e = ex(S_FETCH, 0);
        cyc("reset_0", e);
        cyc("reset_1", e);
        rst_v = 1'b0;

        // lw, mem_ready tied high: 5 cycles
        op_v = 6'h23;
        fetch1("lw_fetch");
        cyc("lw_decode", ex(S_DECODE, 0));
        cyc("lw_memadr", ex(S_MEMADR, 0));
        cyc("lw_memread", ex(S_MEMREAD, 0));
        cyc("lw_memwb", ex(S_MEMWB, 0));

        // sw with three wait cycles in MEMWRITE
        op_v = 6'h2B;
        fetch1("sw_fetch");
        cyc("sw_decode", ex(S_DECODE, 0));
        cyc("sw_memadr", ex(S_MEMADR, 0));
        rdy_v = 1'b0;
        for (int i = 0; i < 3; i++) cyc("sw_wait", ex(S_MEMWRITE, i));
        rdy_v = 1'b1;
        cyc("sw_done", ex(S_MEMWRITE, 3));

        // R-type sub / slt / or
        op_v = 6'h00; fn_v = 6'h22;
        fetch1("sub_fetch");
        cyc("sub_decode", ex(S_DECODE, 0));
        e = ex(S_EXECUTE, 0); e.alu_control = 3'b110; cyc("sub_exec", e);
        cyc("sub_aluwb", ex(S_ALUWB, 0));
        fn_v = 6'h2A;
        fetch1("slt_fetch");
        cyc("slt_decode", ex(S_DECODE, 0));
        e = ex(S_EXECUTE, 0); e.alu_control = 3'b111; cyc("slt_exec", e);
        cyc("slt_aluwb", ex(S_ALUWB, 0));
        fn_v = 6'h25;
        fetch1("or_fetch");
        cyc("or_decode", ex(S_DECODE, 0));
        e = ex(S_EXECUTE, 0); e.alu_control = 3'b001; cyc("or_exec", e);
        cyc("or_aluwb", ex(S_ALUWB, 0));

        // beq taken and not taken
        op_v = 6'h04; z_v = 1'b1;
        fetch1("beq_t_fetch");
        cyc("beq_t_decode", ex(S_DECODE, 0));
        e = ex(S_BRANCH, 0); e.pc_en = 1'b1; cyc("beq_t_branch", e);
        z_v = 1'b0;
        fetch1("beq_nt_fetch");
        cyc("beq_nt_decode", ex(S_DECODE, 0));
        cyc("beq_nt_branch", ex(S_BRANCH, 0));

        // addi and j
        op_v = 6'h08;
        fetch1("addi_fetch");
        cyc("addi_decode", ex(S_DECODE, 0));
        cyc("addi_exec", ex(S_ADDIEXEC, 0));
        cyc("addi_wb", ex(S_ADDIWB, 0));
        op_v = 6'h02;
        fetch1("j_fetch");
        cyc("j_decode", ex(S_DECODE, 0));
        cyc("j_jump", ex(S_JUMP, 0));

        // FETCH stall, then illegal op 0x3F
        op_v = 6'h3F; rdy_v = 1'b0;
        cyc("fetch_wait0", ex(S_FETCH, 0));
        cyc("fetch_wait1", ex(S_FETCH, 1));
        rdy_v = 1'b1;
        e = ex(S_FETCH, 2); e.ir_write = 1'b1; e.pc_en = 1'b1; cyc("fetch_wait_done", e);
        cyc("ill_op_decode", ex(S_DECODE, 0));
        op_v = 6'h00; fn_v = 6'h08;
        e = ex(S_FETCH, 0); e.ir_write = 1'b1; e.pc_en = 1'b1; e.illegal_op = 1'b1;
        cyc("ill_op_pulse", e);
        cyc("ill_fn_decode", ex(S_DECODE, 0));
        op_v = 6'h23;
        e = ex(S_FETCH, 0); e.ir_write = 1'b1; e.pc_en = 1'b1; e.illegal_op = 1'b1;
        cyc("ill_fn_pulse", e);

        // lw timeout in MEMREAD
        cyc("to_lw_decode", ex(S_DECODE, 0));
        cyc("to_lw_memadr", ex(S_MEMADR, 0));
        rdy_v = 1'b0;
        for (int i = 0; i <= 16; i++) cyc("to_lw_wait", ex(S_MEMREAD, i));
        to_exp = 1'b1;
        op_v = 6'h2B;
        fetch1("to_lw_fetch");

        // sw timeout in MEMWRITE: no mem_write in the timeout cycle
        cyc("to_sw_decode", ex(S_DECODE, 0));
        cyc("to_sw_memadr", ex(S_MEMADR, 0));
        rdy_v = 1'b0;
        for (int i = 0; i < 16; i++) cyc("to_sw_wait", ex(S_MEMWRITE, i));
        e = ex(S_MEMWRITE, 16); e.mem_write = 1'b0; cyc("to_sw_expire", e);
        op_v = 6'h00; fn_v = 6'h20;
        fetch1("to_sw_fetch");

        // reset asserted in ALUWB
        cyc("rst_add_decode", ex(S_DECODE, 0));
        cyc("rst_add_exec", ex(S_EXECUTE, 0));
        rst_v = 1'b1;
        e = ex(S_FETCH, 0); e.state = S_ALUWB; cyc("rst_in_aluwb", e);
        rst_v = 1'b0; to_exp = 1'b0; rdy_v = 1'b0;
        cyc("post_reset", ex(S_FETCH, 0));

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS datapath, the successor to singleCyclePro's combinational decoder.
- Sequences one instruction over 3–5 cycles on a shared instruction/data memory port.
- Drives every datapath mux select and write enable, and waits on a memory-ready handshake.
- Sits beside the datapath inside the processor top; the top-level bench interface (memWriteData, memDataAddr, memWrite) is unchanged.

Parameters:
- TIMEOUT, 16: max cycles to wait for mem_ready in a wait state; 0 disables the timeout.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock (single clock domain).
- reset  in  1  synchronous, active-high reset.
- op  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_en  out  1  PC register load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = memory data.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_control  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal_op  out  1  one-cycle pulse on an unsupported op or funct.
- mem_timeout  out  1  sticky flag: a memory wait exceeded TIMEOUT.

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - On reset: state = FETCH, wait counter = 0, mem_timeout = 0, illegal_op = 0.
  - While reset is high, pc_en, mem_write, ir_write and reg_write are forced to 0. All other outputs show their FETCH values.
- Output timing:
  - All outputs are a function of state only (Moore), except two terms: pc_en in BRANCH and the FETCH write enables, which are gated by mem_ready.
  - Outputs default to 0 / 00 / alu_control 010 unless listed for a state below.
- States, outputs and transitions:
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, add. ir_write = pc_en = mem_ready. Goes to DECODE when mem_ready, otherwise stays.
  - DECODE: alu_src_a=0, alu_src_b=11, add (precomputes the branch target). Next state by op:
    - 0x23 (lw) or 0x2B (sw) -> MEMADR.
    - 0x00 with legal funct -> EXECUTE.
    - 0x04 (beq) -> BRANCH.
    - 0x08 (addi) -> ADDIEXEC.
    - 0x02 (j) -> JUMP.
    - Anything else, including op 0x00 with an illegal funct -> FETCH with illegal_op pulsed for one cycle.
  - MEMADR: alu_src_a=1, alu_src_b=10, add. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: iord=1. Goes to MEMWB on mem_ready.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
  - MEMWRITE: iord=1, mem_write=1, held until mem_ready. Goes to FETCH on mem_ready.
  - EXECUTE: alu_src_a=1, alu_src_b=00. alu_control from funct: 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111. Goes to ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en = zero. Goes to FETCH.
  - ADDIEXEC: alu_src_a=1, alu_src_b=10, add. Goes to ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
  - JUMP: pc_src=10, pc_en=1. Goes to FETCH.
- Latency with mem_ready tied to 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- Wait counter:
  - Counts up in FETCH, MEMREAD and MEMWRITE while mem_ready=0; clears on any state change.
  - When TIMEOUT != 0 and the count reaches TIMEOUT with mem_ready still 0, the next state is FETCH. No write enable asserts in that cycle, and mem_timeout sets.
  - mem_timeout is cleared only by reset.
- mem_ready in a non-wait state is ignored.
- Reset asserted mid-instruction: the FSM is in FETCH on the next edge. No write enable is asserted in the reset cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - ALU control codes;
  - the alu_src_b and pc_src encodings.
- One sub-module, alu_decoder: combinational funct -> alu_control and funct_legal. The FSM instantiates it for the EXECUTE state.

Test Plan:
1. Reset, then op=0x23 with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and mem_to_reg=1 only in cycle 5; ir_write=1 only in cycle 1.
2. op=0x2B with mem_ready low for 3 cycles in MEMWRITE -> mem_write held high for 4 cycles, then FETCH. Counter shows 3 before clearing; mem_timeout stays 0.
3. op=0x00, funct=0x22 -> alu_control=110 in EXECUTE, reg_dst=1 and reg_write=1 in ALUWB. Repeat with funct=0x2A -> alu_control=111.
4. op=0x04: zero=1 -> pc_en=1 with pc_src=01 in cycle 3. Zero=0 -> pc_en=0. Both cases return to FETCH in cycle 4.
5. op=0x3F, then op=0x00 with funct=0x08 -> illegal_op high for exactly one cycle after DECODE, FETCH next, no reg_write.
6. TIMEOUT=16 with mem_ready=0 in MEMREAD -> after 16 cycles mem_timeout=1 and state=FETCH. Reset asserted in ALUWB -> reg_write=0 that cycle, state=FETCH, mem_timeout=0.
